freq_meter: RTL and testbench

Gated frequency/period meter that sits directly downstream of the frequency divider. Samples a single-bit clock-domain-synchronous signal (normally the divider's square-wave `out` or one of its tap bits) over a fixed gate window of `clk` cycles. Reports the rising-edge count and the last complete period, in `clk` cycles, through a valid/ready result handshake. Used for on-chip self-check of divider ratios and as a generic rate monitor.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/edge_rise_det.sv | 22 ++
 rtl/freq_meter.sv | 166 ++++++++++++++++
 tb/tb_freq_meter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency/period meter.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GATE = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic int gate_cnt_w(input int gate_cycles);
      return $clog2(gate_cycles);
   endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Registered one-cycle delay of a clk-synchronous level and a same-cycle rising-edge pulse.
module edge_rise_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_d;

   // previous-cycle sample, updated every cycle regardless of consumer state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sig_d <= 1'b0;
      end else begin
         r_sig_d <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter and last-period meter with a valid/ready result hold.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 256,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sig_in,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_count,
   output logic [CNT_W-1:0] o_period,
   output logic             o_overflow,
   output logic             o_valid
);

   localparam int               GW        = gate_cnt_w(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 32'sd1);
   localparam logic [GW-1:0]    GATE_ONE  = GW'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   state_t           r_state, w_state_nxt;
   logic [GW-1:0]    r_gate_cnt;
   logic [CNT_W-1:0] r_edge_cnt, r_per_cnt, r_per_reg;
   logic [CNT_W-1:0] w_edge_cnt_nxt, w_per_cnt_nxt, w_per_reg_nxt;
   logic             r_seen, w_seen_nxt, r_ovf, w_ovf_nxt;
   logic [CNT_W-1:0] r_count, r_period;
   logic             r_overflow, r_valid;
   logic             w_rise, w_clear, w_load, w_accept;

   edge_rise_det u_edge (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_sig (i_sig_in),
      .o_rise(w_rise)
   );

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state; w_clear marks every entry into GATE
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_en) begin
               w_state_nxt = GATE;
               w_clear     = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GATE: begin
            if (!i_en) begin
               w_state_nxt = IDLE;
            end else if (r_gate_cnt == GATE_LAST) begin
               w_state_nxt = HOLD;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = GATE;
            end
         end
         HOLD: begin
            if (r_valid && i_ready) begin
               w_accept = 1'b1;
               if (i_en) begin
                  w_state_nxt = GATE;
                  w_clear     = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // period counter starts at the first edge and restarts at 1 on each later edge
   always_comb begin
      w_edge_cnt_nxt = r_edge_cnt;
      w_per_cnt_nxt  = r_per_cnt;
      w_per_reg_nxt  = r_per_reg;
      w_seen_nxt     = r_seen;
      w_ovf_nxt      = r_ovf;
      if (w_rise) begin
         if (r_edge_cnt == CNT_MAX) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_edge_cnt_nxt = r_edge_cnt + CNT_ONE;
         end
         if (r_seen) begin
            w_per_reg_nxt = r_per_cnt;
         end else begin
            w_seen_nxt = 1'b1;
         end
         w_per_cnt_nxt = CNT_ONE;
      end else if (r_seen) begin
         if (r_per_cnt == CNT_MAX) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_per_cnt_nxt = r_per_cnt + CNT_ONE;
         end
      end else begin
         w_per_cnt_nxt = r_per_cnt;
      end
   end

   // window accumulators, only advanced while gating
   always_ff @(posedge i_clk) begin
      if (i_rst || w_clear) begin
         r_gate_cnt <= {GW{1'b0}};
         r_edge_cnt <= CNT_ZERO;
         r_per_cnt  <= CNT_ZERO;
         r_per_reg  <= CNT_ZERO;
         r_seen     <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (r_state == GATE) begin
         r_gate_cnt <= r_gate_cnt + GATE_ONE;
         r_edge_cnt <= w_edge_cnt_nxt;
         r_per_cnt  <= w_per_cnt_nxt;
         r_per_reg  <= w_per_reg_nxt;
         r_seen     <= w_seen_nxt;
         r_ovf      <= w_ovf_nxt;
      end
   end

   // result load includes any edge on the final gate cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count    <= CNT_ZERO;
         r_period   <= CNT_ZERO;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end else if (w_load) begin
         r_count    <= w_edge_cnt_nxt;
         r_period   <= w_per_reg_nxt;
         r_overflow <= w_ovf_nxt;
         r_valid    <= 1'b1;
      end else if (w_accept) begin
         r_valid    <= 1'b0;
      end
   end

   assign o_count    = r_count;
   assign o_period   = r_period;
   assign o_overflow = r_overflow;
   assign o_valid    = r_valid;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: nominal 256/16 instance plus a 64/4 saturation instance.
module tb_freq_meter;

   logic        clk = 1'b0;
   logic        rst, en, sig_in, ready;
   logic [15:0] count, period;
   logic        ovf, valid;
   logic        en2, sig2, ready2;
   logic [3:0]  count2, period2;
   logic        ovf2, valid2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mode    = 0;
   int lat     = 0;
   int nvalid  = 0;

   always #5 clk = ~clk;

   freq_meter #(.GATE_CYCLES(256), .CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_sig_in(sig_in), .i_ready(ready),
      .o_count(count), .o_period(period), .o_overflow(ovf), .o_valid(valid)
   );

   freq_meter #(.GATE_CYCLES(64), .CNT_W(4)) u_dut_sat (
      .i_clk(clk), .i_rst(rst), .i_en(en2), .i_sig_in(sig2), .i_ready(ready2),
      .o_count(count2), .o_period(period2), .o_overflow(ovf2), .o_valid(valid2)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // mode 0: sig_in driven directly; 1: divide-by-16 square wave; 2: toggle every cycle
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         if (mode == 1) sig_in = cyc[3];
         else if (mode == 2) sig_in = cyc[0];
         sig2 = cyc[0];
      end
   endtask

   task automatic wait_valid(input int limit, output int l);
      l = 0;
      while (valid !== 1'b1 && l < limit) begin
         step(1);
         l++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sig_in = 1'b0; ready = 1'b0;
      en2 = 1'b0; sig2 = 1'b0; ready2 = 1'b1;
      step(3);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_period", period, 0);
      check_eq("rst_ovf", ovf, 0);
      check_eq("rst_valid2", valid2, 0);
      rst = 1'b0;
      step(1);

      // divide-by-16, back-to-back windows
      mode = 1; step(5);
      ready = 1'b1; en = 1'b1;
      wait_valid(300, lat);
      check_eq("div16_latency", lat, 257);
      check_eq("div16_count", count, 16);
      check_eq("div16_period", period, 16);
      check_eq("div16_ovf", ovf, 0);
      step(1);
      check_eq("div16_valid_drop", valid, 0);
      wait_valid(300, lat);
      check_eq("div16_spacing", lat + 1, 257);
      check_eq("div16_count_2", count, 16);
      en = 1'b0;
      step(1);

      // constant high level, then a single edge mid-window
      mode = 0; sig_in = 1'b1; step(5);
      check_eq("idle_valid", valid, 0);
      en = 1'b1;
      wait_valid(300, lat);
      check_eq("const_latency", lat, 257);
      check_eq("const_count", count, 0);
      check_eq("const_period", period, 0);
      en = 1'b0; step(1);
      sig_in = 1'b0; step(3);
      en = 1'b1; step(100);
      sig_in = 1'b1;
      wait_valid(300, lat);
      check_eq("single_count", count, 1);
      check_eq("single_period", period, 0);
      check_eq("single_ovf", ovf, 0);
      en = 1'b0; step(1);

      // backpressure: 50 HOLD cycles with edges present
      mode = 1; step(5);
      ready = 1'b0; en = 1'b1;
      wait_valid(300, lat);
      check_eq("bp_count", count, 16);
      for (int i = 0; i < 50; i++) begin
         if (i == 0) mode = 2;
         if (i == 30) mode = 1;
         step(1);
         check_eq("bp_hold_valid", valid, 1);
         check_eq("bp_hold_fields", {count, period}, {16'd16, 16'd16});
      end
      ready = 1'b1;
      step(1);
      check_eq("bp_valid_drop", valid, 0);
      wait_valid(300, lat);
      check_eq("bp_next_latency", lat + 1, 257);
      check_eq("bp_next_fields", {count, period}, {16'd16, 16'd16});
      en = 1'b0; step(1);

      // abort mid-window: no result, previous result kept
      mode = 0; sig_in = 1'b1; step(2);
      en = 1'b1; step(101);
      en = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (valid === 1'b1) nvalid++;
      end
      check_eq("abort_no_valid", nvalid, 0);
      check_eq("abort_fields_held", {count, period}, {16'd16, 16'd16});
      check_eq("abort_ovf_held", ovf, 0);

      // reset during HOLD
      mode = 1; step(5);
      ready = 1'b0; en = 1'b1;
      wait_valid(300, lat);
      check_eq("prerst_valid", valid, 1);
      en = 1'b0; rst = 1'b1;
      step(1);
      check_eq("hold_rst_valid", valid, 0);
      check_eq("hold_rst_fields", {count, period}, 32'd0);
      check_eq("hold_rst_ovf", ovf, 0);
      rst = 1'b0; step(3);
      check_eq("post_rst_valid", valid, 0);

      // edge on the last gate cycle is counted; one cycle later is not
      mode = 0; sig_in = 1'b0; ready = 1'b0; step(3);
      en = 1'b1; step(256);
      sig_in = 1'b1;
      wait_valid(10, lat);
      check_eq("last_edge_latency", lat, 1);
      check_eq("last_edge_count", count, 1);
      en = 1'b0; ready = 1'b1; step(1);
      sig_in = 1'b0; step(3);
      ready = 1'b0; en = 1'b1; step(257);
      sig_in = 1'b1;
      wait_valid(10, lat);
      check_eq("late_edge_latency", lat, 0);
      check_eq("late_edge_count", count, 0);
      en = 1'b0; ready = 1'b1; step(2);

      // saturation instance: toggle every cycle, 64-cycle gate, 4-bit fields
      en2 = 1'b1; lat = 0;
      while (valid2 !== 1'b1 && lat < 100) begin
         step(1);
         lat++;
      end
      check_eq("sat_latency", lat, 65);
      check_eq("sat_count", count2, 15);
      check_eq("sat_period", period2, 2);
      check_eq("sat_ovf", ovf2, 1);
      en2 = 1'b0; step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
